// File: rtl/ovf_pkg.sv
// Shared types for the overflow-range table controller and its arbiter.
package ovf_pkg;

  localparam int unsigned OVF_AW      = 32;
  localparam int unsigned EVICT_CNT_W = 16;

  typedef struct packed {
    logic              valid;
    logic [OVF_AW-1:0] start;
    logic [OVF_AW-1:0] end_;
  } ovf_range_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ovf_ctrl_state_e;

endpackage

// File: rtl/ovf_rr_arb.sv
// Round-robin priority picker: first asserted request at or above ptr_i, wrapping.
module ovf_rr_arb #(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned IW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic [NR_REQ-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic [IW-1:0]     idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    // Upper segment [ptr, NR_REQ) first, then the wrapped segment [0, ptr).
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && req_i[i] && (i < int'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ovf_range_ctrl.sv
// Overflow-range table: round-robin insert from trackers, sequenced flush,
// combinational address-in-range lookup for the load checker.
module ovf_range_ctrl
  import ovf_pkg::*;
#(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = OVF_AW
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NR_REQ-1:0]               req_valid_i,
  output logic [NR_REQ-1:0]               req_ready_o,
  input  logic [NR_REQ-1:0][AW-1:0]       req_start_i,
  input  logic [NR_REQ-1:0][AW-1:0]       req_end_i,
  input  logic                            flush_i,
  output logic                            flush_done_o,
  output logic                            busy_o,
  input  logic [AW-1:0]                   lookup_addr_i,
  output logic                            lookup_hit_o,
  output logic [$clog2(DEPTH)-1:0]        lookup_idx_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic [EVICT_CNT_W-1:0]          evict_cnt_o
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CNTW = IDXW + 1;
  localparam int unsigned RIW  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  function automatic logic [EVICT_CNT_W-1:0] sat_inc(input logic [EVICT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ovf_ctrl_state_e         state_q, state_d;
  logic [IDXW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [IDXW-1:0]         fl_idx_q, fl_idx_d;
  logic [RIW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]         count_q, count_d;
  logic [EVICT_CNT_W-1:0]  evict_q, evict_d;
  logic                    done_q, done_d;
  ovf_range_t              tbl_q [DEPTH];

  logic [NR_REQ-1:0] gnt;
  logic [RIW-1:0]    gnt_idx;
  logic              grant_en, hs, bad_order, dup, ins_en, hit;
  logic [AW-1:0]     sel_start, sel_end;
  logic [IDXW-1:0]   hit_idx;

  ovf_rr_arb #(.NR_REQ(NR_REQ), .IW(RIW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Flush wins over a same-cycle request; ready also drops while reset is held.
  assign grant_en    = rst_ni && (state_q == IDLE) && !flush_i;
  assign req_ready_o = grant_en ? gnt : '0;
  assign hs          = |req_ready_o;
  assign sel_start   = req_start_i[gnt_idx];
  assign sel_end     = req_end_i[gnt_idx];
  assign bad_order   = sel_start > sel_end;
  assign ins_en      = hs && !bad_order && !dup;

  always_comb begin
    dup     = 1'b0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && (tbl_q[i].start == sel_start) && (tbl_q[i].end_ == sel_end))
        dup = 1'b1;
      if (tbl_q[i].valid && (lookup_addr_i >= tbl_q[i].start) &&
          (lookup_addr_i <= tbl_q[i].end_)) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fl_idx_d = fl_idx_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    evict_d  = evict_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d  = FLUSH;
          fl_idx_d = '0;
        end else if (hs) begin
          rr_ptr_d = (gnt_idx == RIW'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (ins_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == CNTW'(DEPTH)) evict_d = sat_inc(evict_q);
            else                         count_d = count_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        fl_idx_d = fl_idx_q + 1'b1;
        if (fl_idx_q == IDXW'(DEPTH - 1)) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          count_d  = '0;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fl_idx_q <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      evict_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fl_idx_q <= fl_idx_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      evict_q  <= evict_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (state_q == FLUSH) begin
      tbl_q[fl_idx_q].valid <= 1'b0;
    end else if (ins_en) begin
      tbl_q[wr_ptr_q] <= '{valid: 1'b1, start: sel_start, end_: sel_end};
    end
  end

  assign busy_o       = (state_q == FLUSH);
  assign lookup_hit_o = hit && !busy_o;
  assign lookup_idx_o = hit_idx;
  assign flush_done_o = done_q;
  assign count_o      = count_q;
  assign evict_cnt_o  = evict_q;

endmodule

// File: tb/tb_ovf_range_ctrl.sv
// Directed bench for ovf_range_ctrl (NR_REQ=2, DEPTH=8, AW=32).
module tb_ovf_range_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_start;
  logic [1:0][31:0] req_end;
  logic             flush;
  logic             done;
  logic             busy;
  logic [31:0]      lookup_addr;
  logic             hit;
  logic [2:0]       idx;
  logic [3:0]       count;
  logic [15:0]      evict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ovf_range_ctrl #(.NR_REQ(2), .DEPTH(8), .AW(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_start_i   (req_start),
    .req_end_i     (req_end),
    .flush_i       (flush),
    .flush_done_o  (done),
    .busy_o        (busy),
    .lookup_addr_i (lookup_addr),
    .lookup_hit_o  (hit),
    .lookup_idx_o  (idx),
    .count_o       (count),
    .evict_cnt_o   (evict)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic insert(input int r, input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_start[r] = s;
    req_end[r]   = e;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic drive_lookup(input logic [31:0] a);
    @(negedge clk);
    lookup_addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; flush = 1'b0; lookup_addr = '0;
    req_start = '0; req_end = '0;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, done, busy, hit, idx, count, evict} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b done=%b busy=%b hit=%b idx=%0d cnt=%0d ev=%0d exp all 0",
               req_ready, done, busy, hit, idx, count, evict);
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_insert();
    @(negedge clk);
    req_valid = 2'b01; req_start[0] = 32'h1000; req_end[0] = 32'h1040;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    drive_lookup(32'h1000);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd0}) begin errors++; $display("FAIL single_lo got hit=%b idx=%0d exp 1/0", hit, idx); end
    drive_lookup(32'h1040);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd0}) begin errors++; $display("FAIL single_hi got hit=%b idx=%0d exp 1/0", hit, idx); end
    drive_lookup(32'h1041);
    checks++;
    if ({hit, idx} !== 4'b0) begin errors++; $display("FAIL single_above got hit=%b idx=%0d exp 0/0", hit, idx); end
    drive_lookup(32'h0FFF);
    checks++;
    if ({hit, idx} !== 4'b0) begin errors++; $display("FAIL single_below got hit=%b idx=%0d exp 0/0", hit, idx); end
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid    = 2'b11;
      req_start[0] = 32'h10000 + 32'(n0) * 32'h100;
      req_end[0]   = req_start[0] + 32'h10;
      req_start[1] = 32'h20000 + 32'(n1) * 32'h100;
      req_end[1]   = req_start[1] + 32'h10;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp); end
      if (exp[0]) n0++; else n1++;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (count !== 4'd4) begin errors++; $display("FAIL rr_count got %0d exp 4", count); end
    drive_lookup(32'h10005);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd0}) begin errors++; $display("FAIL rr_idx0 got hit=%b idx=%0d exp 1/0", hit, idx); end
    drive_lookup(32'h20000);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd1}) begin errors++; $display("FAIL rr_idx1 got hit=%b idx=%0d exp 1/1", hit, idx); end
    drive_lookup(32'h10100);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd2}) begin errors++; $display("FAIL rr_idx2 got hit=%b idx=%0d exp 1/2", hit, idx); end
    drive_lookup(32'h20110);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd3}) begin errors++; $display("FAIL rr_idx3 got hit=%b idx=%0d exp 1/3", hit, idx); end
  endtask

  task automatic test_wrap_evict();
    do_reset();
    for (int k = 1; k <= 10; k++) insert(0, 32'(k) << 12, (32'(k) << 12) + 32'hFF);
    #1;
    checks++;
    if ({count, evict} !== {4'd8, 16'd2}) begin
      errors++; $display("FAIL wrap_count got cnt=%0d ev=%0d exp 8/2", count, evict);
    end
    drive_lookup(32'h1000);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL wrap_r1_miss got hit=%b exp 0", hit); end
    drive_lookup(32'h20FF);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL wrap_r2_miss got hit=%b exp 0", hit); end
    drive_lookup(32'hA080);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd1}) begin errors++; $display("FAIL wrap_r10 got hit=%b idx=%0d exp 1/1", hit, idx); end
    drive_lookup(32'h3000);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd2}) begin errors++; $display("FAIL wrap_r3 got hit=%b idx=%0d exp 1/2", hit, idx); end
    insert(0, 32'hB000, 32'hB0FF);
    drive_lookup(32'hB000);
    checks++;
    if ({hit, idx, evict} !== {1'b1, 3'd2, 16'd3}) begin
      errors++; $display("FAIL wrap_r11 got hit=%b idx=%0d ev=%0d exp 1/2/3", hit, idx, evict);
    end
  endtask

  task automatic test_degenerate();
    do_reset();
    insert(0, 32'h5000, 32'h50FF);
    insert(1, 32'h6000, 32'h60FF);
    @(negedge clk);
    req_valid = 2'b01; req_start[0] = 32'h2000; req_end[0] = 32'h1FFF;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL degen_order_ready got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10; req_start[1] = 32'h5000; req_end[1] = 32'h50FF;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL degen_dup_ready got %b exp 10", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({count, evict} !== {4'd2, 16'd0}) begin
      errors++; $display("FAIL degen_count got cnt=%0d ev=%0d exp 2/0", count, evict);
    end
    insert(0, 32'h7000, 32'h70FF);
    drive_lookup(32'h7000);
    checks++;
    if ({hit, idx} !== {1'b1, 3'd2}) begin errors++; $display("FAIL degen_wrptr got hit=%b idx=%0d exp 1/2", hit, idx); end
  endtask

  task automatic test_flush();
    insert(0, 32'h8000, 32'h80FF);
    insert(1, 32'h9000, 32'h90FF);
    @(negedge clk);
    flush = 1'b1; req_valid = 2'b01; req_start[0] = 32'hC000; req_end[0] = 32'hC0FF;
    lookup_addr = 32'h5000;
    #1;
    checks++;
    if ({req_ready, hit, count} !== {2'b00, 1'b1, 4'd5}) begin
      errors++; $display("FAIL flush_entry got rdy=%b hit=%b cnt=%0d exp 00/1/5", req_ready, hit, count);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) flush = 1'b0;
      if (k == 2) flush = 1'b1;
      if (k == 3) flush = 1'b0;
      #1;
      checks++;
      if ({busy, hit, done, req_ready} !== 5'b10000) begin
        errors++;
        $display("FAIL flush_cyc%0d got busy=%b hit=%b done=%b rdy=%b exp 1/0/0/00", k, busy, hit, done, req_ready);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, done, count, req_ready, hit} !== {1'b0, 1'b1, 4'd0, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL flush_done got busy=%b done=%b cnt=%0d rdy=%b hit=%b exp 0/1/0/01/0", busy, done, count, req_ready, hit);
    end
    @(negedge clk);
    req_valid = '0; lookup_addr = 32'hC000;
    #1;
    checks++;
    if ({done, count, hit, idx} !== {1'b0, 4'd1, 1'b1, 3'd0}) begin
      errors++; $display("FAIL flush_after got done=%b cnt=%0d hit=%b idx=%0d exp 0/1/1/0", done, count, hit, idx);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 4; k++) insert(1, 32'(k) << 12, (32'(k) << 12) + 32'hFF);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lookup_addr = 32'h4000; req_valid = 2'b01; req_start[0] = 32'hE000; req_end[0] = 32'hE0FF;
    #1;
    checks++;
    if ({busy, count} !== {1'b1, 4'd5}) begin errors++; $display("FAIL arst_pre got busy=%b cnt=%0d exp 1/5", busy, count); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, done, busy, hit, idx, count, evict} !== '0) begin
      errors++;
      $display("FAIL arst_outputs rdy=%b done=%b busy=%b hit=%b idx=%0d cnt=%0d ev=%0d exp all 0",
               req_ready, done, busy, hit, idx, count, evict);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({busy, req_ready, count, hit} !== {1'b0, 2'b01, 4'd0, 1'b0}) begin
      errors++; $display("FAIL arst_idle got busy=%b rdy=%b cnt=%0d hit=%b exp 0/01/0/0", busy, req_ready, count, hit);
    end
    @(negedge clk);
    req_valid = '0;
    drive_lookup(32'hE000);
    checks++;
    if ({count, hit, idx} !== {4'd1, 1'b1, 3'd0}) begin
      errors++; $display("FAIL arst_insert got cnt=%0d hit=%b idx=%0d exp 1/1/0", count, hit, idx);
    end
    drive_lookup(32'h4000);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL arst_cleared got hit=%b exp 0", hit); end
  endtask

  initial begin
    test_reset();
    test_single_insert();
    test_round_robin();
    test_wrap_evict();
    test_degenerate();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ovf_range_ctrl.md
Name: ovf_range_ctrl

Overview:
- Controller for the shared overflow-range table used by the load checker.
- Accepts detected overflow ranges [start,end] from several tracker units (heap, stack, ...) over valid/ready ports and arbitrates them round-robin into a DEPTH-entry circular table.
- Sequences software- or crash-triggered flushes of the table and answers combinational address-in-range lookups for the load path.

Parameters:
- NR_REQ, 2, number of range-producing requesters.
- DEPTH, 8, table entries (power of two).
- AW, 32, address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_valid_i  in  NR_REQ  requester has a range to insert.
- req_ready_o  out  NR_REQ  range accepted this cycle (one-hot or zero).
- req_start_i  in  NR_REQ x AW  first byte address of range.
- req_end_i  in  NR_REQ x AW  last byte address of range (inclusive).
- flush_i  in  1  request to clear the whole table.
- flush_done_o  out  1  one-cycle pulse when flush completes.
- busy_o  out  1  high while in FLUSH.
- lookup_addr_i  in  AW  address to check.
- lookup_hit_o  out  1  address inside a valid entry.
- lookup_idx_o  out  log2(DEPTH)  lowest matching entry index.
- count_o  out  log2(DEPTH)+1  valid entries.
- evict_cnt_o  out  16  saturating count of oldest-entry overwrites.

Behaviour:
- Reset (rst_ni asynchronous, active-low; clock clk_i): state IDLE, all entry valid bits 0, wr_ptr 0, rr_ptr 0, count 0, evict_cnt 0. All outputs 0.
- States:
  - IDLE: arbitrate and insert.
  - FLUSH: clear entries.
- IDLE arbitration:
  - Grant goes to the first requester with valid=1, searching from rr_ptr upward modulo NR_REQ.
  - req_ready_o[g] is asserted combinationally in the same cycle; at most one ready per cycle.
  - On handshake (valid & ready), rr_ptr <= (g+1) mod NR_REQ.
  - Requesters hold start/end stable until ready.
- Insert on handshake, effective next cycle:
  - Entry at wr_ptr <= {valid=1, start, end}.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
  - If count < DEPTH: count+1. If count == DEPTH: the oldest entry is overwritten, count stays DEPTH, evict_cnt+1 (saturates at 0xFFFF).
- Degenerate requests are accepted (ready=1) but produce no table change; rr_ptr still advances.
  - start > end (unsigned): dropped.
  - Exact start/end match with an existing valid entry: duplicate, dropped.
- flush_i in IDLE:
  - Enter FLUSH the next cycle. flush has priority over requests in the same cycle: all ready=0 that cycle.
  - In FLUSH: ready all 0, busy_o=1. One entry is cleared per cycle, index 0 to DEPTH-1, so the flush lasts DEPTH cycles.
  - On the cycle that clears the last entry: wr_ptr <= 0, count <= 0, evict_cnt unchanged. flush_done_o pulses high the following cycle, together with return to IDLE.
  - flush_i asserted during FLUSH is ignored, not queued.
- Lookup:
  - Purely combinational: hit if some valid entry has start <= addr <= end (unsigned, inclusive both ends).
  - lookup_idx_o is the lowest matching index, 0 on miss.
  - lookup_hit_o is forced 0 while busy_o=1.
  - An entry written by a handshake in cycle N is visible to lookup from cycle N+1.
- Reset mid-flush or mid-handshake returns to the reset state immediately; a pending insert is lost.

Decomposition:
- Shared package ovf_pkg:
  - ovf_range_t struct {valid, start[AW], end_[AW]}.
  - ovf_ctrl_state_e enum {IDLE, FLUSH}.
  - EVICT_CNT_W = 16.
- One sub-module ovf_rr_arb: parameterised NR_REQ round-robin priority picker. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and the grant index. Purely combinational. rr_ptr state stays in ovf_range_ctrl.

Test Plan:
- Single insert:
  - Stimulus: req0 valid, start 0x1000, end 0x1040.
  - Required: ready0 the same cycle. Next cycle count=1 and lookups return hit=1 idx=0 at 0x1000, hit=1 at 0x1040, hit=0 at 0x1041 and 0x0FFF.
- Round-robin:
  - Stimulus: req0 and req1 valid continuously with distinct ranges, rr_ptr=0.
  - Required: grants 0,1,0,1 on consecutive cycles; never two readies in one cycle.
- Wrap and evict (DEPTH=8):
  - Stimulus: insert 10 distinct ranges.
  - Required: count=8, evict_cnt=2, wr_ptr=2. Ranges 1 and 2 miss; range 10 hits at idx 1.
- Degenerate requests:
  - Stimulus: insert start 0x2000 end 0x1FFF, then re-insert an existing range.
  - Required: both acknowledged; count unchanged; evict_cnt unchanged.
- Flush:
  - Stimulus: with 5 entries, assert flush_i together with req0 valid.
  - Required: ready0=0. busy_o high for 8 cycles, lookup_hit_o=0 throughout. flush_done_o pulses once, then count=0. The held req0 is accepted in the first IDLE cycle at idx 0.
- Asynchronous reset:
  - Stimulus: drop rst_ni during FLUSH (cycle 3).
  - Required: all outputs 0 immediately; after release, state IDLE and table empty.
